// File: rtl/cpu_ctrl_pkg.sv
//============================================================================
// Module   : cpu_ctrl_pkg
// Brief    : Opcode, ALU-code and FSM-state constants shared by the
//            multi-cycle control unit and its ALU decoder.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package cpu_ctrl_pkg;

    localparam int c_OP_W   = 6;
    localparam int c_FUNC_W = 4;
    localparam int c_ALU_W  = 3;
    localparam int c_ST_W   = 3;

    // Primary opcodes
    localparam logic [c_OP_W-1:0] c_OP_R   = 6'b000000;
    localparam logic [c_OP_W-1:0] c_OP_J   = 6'b000010;
    localparam logic [c_OP_W-1:0] c_OP_BEQ = 6'b000100;
    localparam logic [c_OP_W-1:0] c_OP_ORI = 6'b001101;
    localparam logic [c_OP_W-1:0] c_OP_LW  = 6'b100011;
    localparam logic [c_OP_W-1:0] c_OP_SW  = 6'b101011;

    // R-type function field values
    localparam logic [c_FUNC_W-1:0] c_FUNC_ADD = 4'b0000;
    localparam logic [c_FUNC_W-1:0] c_FUNC_SUB = 4'b0010;
    localparam logic [c_FUNC_W-1:0] c_FUNC_AND = 4'b0100;
    localparam logic [c_FUNC_W-1:0] c_FUNC_OR  = 4'b0101;
    localparam logic [c_FUNC_W-1:0] c_FUNC_SLT = 4'b1010;

    // ALU operation codes
    localparam logic [c_ALU_W-1:0] c_ALU_ADD = 3'd0;
    localparam logic [c_ALU_W-1:0] c_ALU_SUB = 3'd1;
    localparam logic [c_ALU_W-1:0] c_ALU_AND = 3'd2;
    localparam logic [c_ALU_W-1:0] c_ALU_OR  = 3'd3;
    localparam logic [c_ALU_W-1:0] c_ALU_SLT = 3'd4;

    // FSM state encoding
    localparam logic [c_ST_W-1:0] c_ST_FETCH  = 3'd0;
    localparam logic [c_ST_W-1:0] c_ST_DECODE = 3'd1;
    localparam logic [c_ST_W-1:0] c_ST_EXEC   = 3'd2;
    localparam logic [c_ST_W-1:0] c_ST_MEM    = 3'd3;
    localparam logic [c_ST_W-1:0] c_ST_WB     = 3'd4;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_J   = 3'd1,
        CLS_BEQ = 3'd2,
        CLS_ORI = 3'd3,
        CLS_LW  = 3'd4,
        CLS_SW  = 3'd5,
        CLS_ILL = 3'd6
    } instr_class_e;

    // Opcode-only classification; R-type func legality is judged by alu_ctrl.
    function automatic instr_class_e op_class(input logic [c_OP_W-1:0] op);
        instr_class_e cls;
        case (op)
            c_OP_R:   cls = CLS_R;
            c_OP_J:   cls = CLS_J;
            c_OP_BEQ: cls = CLS_BEQ;
            c_OP_ORI: cls = CLS_ORI;
            c_OP_LW:  cls = CLS_LW;
            c_OP_SW:  cls = CLS_SW;
            default:  cls = CLS_ILL;
        endcase
        return cls;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_ctrl.sv
//============================================================================
// Module   : alu_ctrl
// Brief    : Combinational (op, func) -> ALU code decoder with illegal flag.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module alu_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W   = 6,
    parameter int FUNC_W = 4,
    parameter int ALU_W  = 3
) (
    input  logic [OP_W-1:0]   i_op,
    input  logic [FUNC_W-1:0] i_func,
    output logic [ALU_W-1:0]  o_alu_func,
    output logic              o_illegal
);

    always_comb begin
        o_alu_func = ALU_W'(c_ALU_ADD);
        o_illegal  = 1'b0;
        case (i_op)
            c_OP_R: begin
                case (i_func)
                    c_FUNC_ADD: o_alu_func = ALU_W'(c_ALU_ADD);
                    c_FUNC_SUB: o_alu_func = ALU_W'(c_ALU_SUB);
                    c_FUNC_AND: o_alu_func = ALU_W'(c_ALU_AND);
                    c_FUNC_OR:  o_alu_func = ALU_W'(c_ALU_OR);
                    c_FUNC_SLT: o_alu_func = ALU_W'(c_ALU_SLT);
                    default:    o_illegal  = 1'b1;
                endcase
            end
            c_OP_BEQ:        o_alu_func = ALU_W'(c_ALU_SUB);
            c_OP_ORI:        o_alu_func = ALU_W'(c_ALU_OR);
            c_OP_LW, c_OP_SW,
            c_OP_J:          o_alu_func = ALU_W'(c_ALU_ADD);
            default:         o_illegal  = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
//============================================================================
// Module   : multicycle_control
// Brief    : Multi-cycle CPU control FSM with instruction register, Moore
//            datapath strobes and a retired-instruction counter.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W   = 6,
    parameter int FUNC_W = 4,
    parameter int ALU_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [FUNC_W-1:0] func,
    input  logic              mem_ready,
    output logic [ALU_W-1:0]  alu_func,
    output logic              ram_load,
    output logic              ram_write,
    output logic              jump,
    output logic              branch,
    output logic              pc_write,
    output logic              reg_write,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_next_state;
    logic [OP_W-1:0]   r_ir_op;
    logic [FUNC_W-1:0] r_ir_func;
    logic [CNT_W-1:0]  r_retired;
    logic [ALU_W-1:0]  w_alu_func;
    logic              w_illegal;
    logic              w_retire;
    instr_class_e      w_class;

    assign w_class = op_class(r_ir_op);

    alu_ctrl #(
        .OP_W   (OP_W),
        .FUNC_W (FUNC_W),
        .ALU_W  (ALU_W)
    ) u_alu_ctrl (
        .i_op       (r_ir_op),
        .i_func     (r_ir_func),
        .o_alu_func (w_alu_func),
        .o_illegal  (w_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_FETCH: begin
                if (instr_valid) begin
                    w_next_state = c_ST_DECODE;
                end
            end
            c_ST_DECODE: begin
                if (w_illegal || (w_class == CLS_J)) begin
                    w_next_state = c_ST_FETCH;
                end else begin
                    w_next_state = c_ST_EXEC;
                end
            end
            c_ST_EXEC: begin
                case (w_class)
                    CLS_BEQ:        w_next_state = c_ST_FETCH;
                    CLS_LW, CLS_SW: w_next_state = c_ST_MEM;
                    default:        w_next_state = c_ST_WB;
                endcase
            end
            c_ST_MEM: begin
                if (mem_ready) begin
                    w_next_state = (w_class == CLS_LW) ? c_ST_WB : c_ST_FETCH;
                end
            end
            c_ST_WB:  w_next_state = c_ST_FETCH;
            default:  w_next_state = c_ST_FETCH;
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        alu_func    = '0;
        ram_load    = 1'b0;
        ram_write   = 1'b0;
        jump        = 1'b0;
        branch      = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            c_ST_FETCH: instr_ready = 1'b1;
            c_ST_DECODE: begin
                illegal = w_illegal;
                if (!w_illegal && (w_class == CLS_J)) begin
                    jump     = 1'b1;
                    pc_write = 1'b1;
                end
            end
            c_ST_EXEC: begin
                alu_func = w_alu_func;
                if (w_class == CLS_BEQ) begin
                    branch   = 1'b1;
                    pc_write = 1'b1;
                end
            end
            c_ST_MEM: begin
                alu_func  = ALU_W'(c_ALU_ADD);
                ram_load  = (w_class == CLS_LW);
                ram_write = (w_class == CLS_SW);
            end
            c_ST_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (w_class == CLS_R);
                mem_to_reg = (w_class == CLS_LW);
            end
            default: ;
        endcase
    end

    // The IR is only written on the accept edge; outside FETCH op/func are don't-care.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir_op   <= '0;
            r_ir_func <= '0;
        end else if ((r_state == c_ST_FETCH) && instr_valid) begin
            r_ir_op   <= op;
            r_ir_func <= func;
        end
    end

    // Every return to FETCH is a retire, except the illegal-instruction exit from DECODE.
    assign w_retire = (r_state != c_ST_FETCH) && (w_next_state == c_ST_FETCH) &&
                      !((r_state == c_ST_DECODE) && w_illegal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 1'b1;
        end
    end

    assign retired = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
//============================================================================
// Module   : tb_multicycle_control
// Brief    : Self-checking bench for multicycle_control (16-bit and 2-bit
//            retire-counter instances driven in lock-step).
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_multicycle_control;

    localparam logic [5:0]  c_OP_R   = 6'b000000;
    localparam logic [5:0]  c_OP_J   = 6'b000010;
    localparam logic [5:0]  c_OP_BEQ = 6'b000100;
    localparam logic [5:0]  c_OP_ORI = 6'b001101;
    localparam logic [5:0]  c_OP_LW  = 6'b100011;
    localparam logic [5:0]  c_OP_SW  = 6'b101011;
    localparam logic [12:0] c_IDLE   = 13'h1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       r_instr_valid;
    logic [5:0] r_op;
    logic [3:0] r_func;
    logic       r_mem_ready;

    logic        w_instr_ready, w_ram_load, w_ram_write, w_jump, w_branch, w_pc_write;
    logic        w_reg_write, w_reg_dst, w_mem_to_reg, w_illegal;
    logic [2:0]  w_alu_func;
    logic [15:0] w_retired;
    logic        w_s_instr_ready, w_s_ram_load, w_s_ram_write, w_s_jump, w_s_branch, w_s_pc_write;
    logic        w_s_reg_write, w_s_reg_dst, w_s_mem_to_reg, w_s_illegal;
    logic [2:0]  w_s_alu_func;
    logic [1:0]  w_s_retired;
    logic [12:0] w_obs, w_s_obs;

    assign w_obs   = {w_instr_ready, w_alu_func, w_ram_load, w_ram_write, w_jump, w_branch,
                      w_pc_write, w_reg_write, w_reg_dst, w_mem_to_reg, w_illegal};
    assign w_s_obs = {w_s_instr_ready, w_s_alu_func, w_s_ram_load, w_s_ram_write, w_s_jump, w_s_branch,
                      w_s_pc_write, w_s_reg_write, w_s_reg_dst, w_s_mem_to_reg, w_s_illegal};

    multicycle_control #(.OP_W(6), .FUNC_W(4), .ALU_W(3), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(r_instr_valid), .instr_ready(w_instr_ready),
        .op(r_op), .func(r_func), .mem_ready(r_mem_ready), .alu_func(w_alu_func),
        .ram_load(w_ram_load), .ram_write(w_ram_write), .jump(w_jump), .branch(w_branch),
        .pc_write(w_pc_write), .reg_write(w_reg_write), .reg_dst(w_reg_dst),
        .mem_to_reg(w_mem_to_reg), .illegal(w_illegal), .retired(w_retired)
    );

    multicycle_control #(.OP_W(6), .FUNC_W(4), .ALU_W(3), .CNT_W(2)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .instr_valid(r_instr_valid), .instr_ready(w_s_instr_ready),
        .op(r_op), .func(r_func), .mem_ready(r_mem_ready), .alu_func(w_s_alu_func),
        .ram_load(w_s_ram_load), .ram_write(w_s_ram_write), .jump(w_s_jump), .branch(w_s_branch),
        .pc_write(w_s_pc_write), .reg_write(w_s_reg_write), .reg_dst(w_s_reg_dst),
        .mem_to_reg(w_s_mem_to_reg), .illegal(w_s_illegal), .retired(w_s_retired)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_ret  = 0;

    typedef enum int {K_R, K_J, K_BEQ, K_ORI, K_LW, K_SW, K_ILL} kind_e;

    typedef struct {
        logic [12:0] outs;
        logic        mr;
    } step_t;

    typedef struct {
        logic [5:0] op;
        logic [3:0] func;
        int         w;
        int         cycles;
        int         alu;
        int         ill_cnt;
        int         rw_cnt;
        int         mem_cnt;
    } vec_t;

    step_t tr_q[$];

    task automatic check_vec(input string name, input logic [12:0] act, input logic [12:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: outputs got %h expected %h", name, act, expv);
        end
    endtask

    task automatic check_val(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic check_retired(input string name);
        check_val({name, " retired"}, int'(w_retired), exp_ret % 65536);
        check_val({name, " retired(cnt2)"}, int'(w_s_retired), exp_ret % 4);
    endtask

    // ---- reference model: instruction rules expressed as a cycle trace ----
    function automatic kind_e classify(input logic [5:0] o, input logic [3:0] f);
        kind_e k;
        case (o)
            6'b000000: k = (f == 4'b0000 || f == 4'b0010 || f == 4'b0100 ||
                            f == 4'b0101 || f == 4'b1010) ? K_R : K_ILL;
            6'b000010: k = K_J;
            6'b000100: k = K_BEQ;
            6'b001101: k = K_ORI;
            6'b100011: k = K_LW;
            6'b101011: k = K_SW;
            default:   k = K_ILL;
        endcase
        return k;
    endfunction

    function automatic logic [2:0] alu_code(input logic [5:0] o, input logic [3:0] f);
        logic [2:0] a;
        a = 3'd0;
        if (o == c_OP_BEQ) a = 3'd1;
        else if (o == c_OP_ORI) a = 3'd3;
        else if (o == c_OP_R) begin
            case (f)
                4'b0010: a = 3'd1;
                4'b0100: a = 3'd2;
                4'b0101: a = 3'd3;
                4'b1010: a = 3'd4;
                default: a = 3'd0;
            endcase
        end
        return a;
    endfunction

    function automatic logic [12:0] mk(input logic rdy, input logic [2:0] alu, input logic ld,
                                       input logic wr, input logic j, input logic br, input logic pcw,
                                       input logic rw, input logic rd, input logic m2r, input logic ill);
        return {rdy, alu, ld, wr, j, br, pcw, rw, rd, m2r, ill};
    endfunction

    function automatic void push(input logic [12:0] o, input logic mr);
        step_t s;
        s.outs = o;
        s.mr   = mr;
        tr_q.push_back(s);
    endfunction

    function automatic void build_trace(input logic [5:0] o, input logic [3:0] f, input int w);
        kind_e      k;
        logic [2:0] a;
        k = classify(o, f);
        a = alu_code(o, f);
        tr_q.delete();
        push(c_IDLE, 1'($urandom));
        if (k == K_ILL) begin
            push(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'($urandom));
            return;
        end
        if (k == K_J) begin
            push(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), 1'($urandom));
            return;
        end
        push(13'h0, 1'($urandom));
        if (k == K_BEQ) begin
            push(mk(0, a, 0, 0, 0, 1, 1, 0, 0, 0, 0), 1'($urandom));
            return;
        end
        push(mk(0, a, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
        if (k == K_LW || k == K_SW) begin
            for (int j = 0; j < w; j++)
                push(mk(0, 0, k == K_LW, k == K_SW, 0, 0, 0, 0, 0, 0, 0), j == w - 1);
        end
        if (k != K_SW)
            push(mk(0, 0, 0, 0, 0, 0, 0, 1, k == K_R, k == K_LW, 0), 1'($urandom));
    endfunction

    // Leaves the bench at the negedge of the instruction's final state.
    task automatic run_instr(input logic [5:0] o, input logic [3:0] f, input int w, input string tag);
        kind_e k;
        k = classify(o, f);
        build_trace(o, f, w);
        for (int i = 0; i < tr_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) check_retired({tag, " start"});
            check_vec($sformatf("%s cyc%0d", tag, i), w_obs, tr_q[i].outs);
            check_vec($sformatf("%s cyc%0d(cnt2)", tag, i), w_s_obs, tr_q[i].outs);
            if (i == 0) begin
                r_instr_valid = 1'b1;
                r_op          = o;
                r_func        = f;
            end else begin
                r_instr_valid = (i == tr_q.size() - 1) ? 1'b0 : 1'($urandom);
                r_op          = 6'($urandom);
                r_func        = 4'($urandom);
            end
            r_mem_ready = tr_q[i].mr;
        end
        if (k != K_ILL) exp_ret++;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int  n, alu_or, ill_cnt, rw_cnt, mem_cnt, mc;
        logic done;
        n = 1; alu_or = 0; ill_cnt = 0; rw_cnt = 0; mem_cnt = 0; mc = 0; done = 1'b0;
        @(negedge clk);
        check_val({tag, " ready"}, int'(w_instr_ready), 1);
        r_instr_valid = 1'b1;
        r_op          = v.op;
        r_func        = v.func;
        r_mem_ready   = 1'b0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            r_instr_valid = 1'b0;
            if (w_instr_ready) done = 1'b1;
            else begin
                n++;
                alu_or  |= int'(w_alu_func);
                ill_cnt += int'(w_illegal);
                rw_cnt  += int'(w_reg_write);
                if (w_ram_load || w_ram_write) begin
                    mem_cnt++;
                    r_mem_ready = (mc == v.w - 1);
                    mc++;
                end else r_mem_ready = 1'b0;
            end
        end
        check_val({tag, " cycles"}, done ? n : -1, v.cycles);
        check_val({tag, " alu_func"}, alu_or, v.alu);
        check_val({tag, " illegal cycles"}, ill_cnt, v.ill_cnt);
        check_val({tag, " reg_write cycles"}, rw_cnt, v.rw_cnt);
        check_val({tag, " ram cycles"}, mem_cnt, v.mem_cnt);
        if (v.ill_cnt == 0) exp_ret++;
        check_retired(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       vecs[12];
        int         wrap_exp[4];
        logic [5:0] ops[6];
        logic [3:0] funcs[5];
        logic [5:0] o;
        logic [3:0] f;
        int         sel;
        int         t;

        vecs[0]  = '{6'b000000, 4'b0000, 1, 4, 0, 0, 1, 0};
        vecs[1]  = '{6'b000000, 4'b0010, 1, 4, 1, 0, 1, 0};
        vecs[2]  = '{6'b000000, 4'b0100, 1, 4, 2, 0, 1, 0};
        vecs[3]  = '{6'b000000, 4'b0101, 1, 4, 3, 0, 1, 0};
        vecs[4]  = '{6'b000000, 4'b1010, 1, 4, 4, 0, 1, 0};
        vecs[5]  = '{6'b000000, 4'b1111, 1, 2, 0, 1, 0, 0};
        vecs[6]  = '{6'b000010, 4'b0000, 1, 2, 0, 0, 0, 0};
        vecs[7]  = '{6'b000100, 4'b0000, 1, 3, 1, 0, 0, 0};
        vecs[8]  = '{6'b001101, 4'b0000, 1, 4, 3, 0, 1, 0};
        vecs[9]  = '{6'b100011, 4'b0000, 4, 8, 0, 0, 1, 4};
        vecs[10] = '{6'b101011, 4'b0000, 2, 5, 0, 0, 0, 2};
        vecs[11] = '{6'b111111, 4'b0000, 1, 2, 0, 1, 0, 0};
        wrap_exp = '{1, 2, 3, 0};
        ops      = '{c_OP_R, c_OP_J, c_OP_BEQ, c_OP_ORI, c_OP_LW, c_OP_SW};
        funcs    = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b1010};

        rst_n         = 1'b0;
        r_instr_valid = 1'b0;
        r_op          = '0;
        r_func        = '0;
        r_mem_ready   = 1'b0;
        #1;
        check_vec("reset asserted", w_obs, c_IDLE);
        check_retired("reset asserted");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_vec("after reset", w_obs, c_IDLE);
        check_retired("after reset");

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back SW then J with no idle cycle between them
        run_instr(c_OP_SW, 4'b0000, 2, "b2b sw");
        run_instr(c_OP_J, 4'b0000, 1, "b2b j");
        @(negedge clk);
        r_instr_valid = 1'b0;
        check_retired("b2b end");

        // Reset while SW sits in MEM
        @(negedge clk);
        r_instr_valid = 1'b1;
        r_op          = c_OP_SW;
        r_func        = 4'b0000;
        r_mem_ready   = 1'b0;
        @(negedge clk);
        r_instr_valid = 1'b0;
        t = 0;
        while (!w_ram_write && t < 10) begin
            @(negedge clk);
            t++;
        end
        check_val("sw reached mem", int'(w_ram_write), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_vec("mid-mem reset outputs", w_obs, c_IDLE);
        exp_ret = 0;
        check_retired("mid-mem reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Four J's wrap the 2-bit counter
        for (int k = 0; k < 4; k++) begin
            run_instr(c_OP_J, 4'b0000, 1, $sformatf("wrap j%0d", k));
            @(negedge clk);
            check_val($sformatf("wrap step%0d", k), int'(w_s_retired), wrap_exp[k]);
        end

        run_instr(c_OP_ORI, 4'b0000, 1, "ori after reset");

        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 7));
            if (sel < 6) o = ops[sel];
            else if (sel == 6) o = 6'($urandom);
            else o = c_OP_R;
            f = (o == c_OP_R && $urandom_range(0, 3) != 0) ? funcs[$urandom_range(0, 4)] : 4'($urandom);
            run_instr(o, f, int'($urandom_range(1, 4)), $sformatf("rnd%0d op=%b f=%b", n, o, f));
        end
        @(negedge clk);
        r_instr_valid = 1'b0;
        check_vec("final idle", w_obs, c_IDLE);
        check_retired("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
